// File: rtl/dpi_pattern_tx_if.sv
// dpi_pattern_tx_if: run control plus RGB/DPI pixel stream between the pattern transmitter and the video sampler
// master (transmitter): in en, pattern_sel, fill; out rgb_clk, rgb_de, rgb_vsync, rgb_data, busy, frame_done, frame_cnt
// slave (sampler/controller): the mirror of master
interface dpi_pattern_tx_if;
    logic       en;
    logic [1:0] pattern_sel;
    logic [3:0] fill;
    logic       rgb_clk;
    logic       rgb_de;
    logic       rgb_vsync;
    logic [3:0] rgb_data;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_cnt;
    modport master (
        input  en, pattern_sel, fill,
        output rgb_clk, rgb_de, rgb_vsync, rgb_data, busy, frame_done, frame_cnt
    );
    modport slave (
        output en, pattern_sel, fill,
        input  rgb_clk, rgb_de, rgb_vsync, rgb_data, busy, frame_done, frame_cnt
    );
endinterface

// File: rtl/dpi_pattern_tx.sv
// dpi_pattern_tx: synthetic RGB/DPI raster generator (solid/gradient/checker/xor) for sampler self-test
// clk_8m/rst: system clock, async active-high reset; bus: dpi_pattern_tx_if.master (run control in, pixel stream and frame status out)
module dpi_pattern_tx #(
    parameter int H_ACTIVE    = 320,
    parameter int H_BLANK     = 40,
    parameter int V_ACTIVE    = 288,
    parameter int V_BLANK     = 8,
    parameter int VSYNC_LINES = 2,
    parameter int CLK_DIV     = 2
) (
    input  logic             clk_8m,
    input  logic             rst,
    dpi_pattern_tx_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int HW      = H_TOTAL > 1 ? $clog2(H_TOTAL) : 1;
    localparam int VW      = V_TOTAL > 1 ? $clog2(V_TOTAL) : 1;
    localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state;
    logic [DW-1:0] div;
    logic [HW-1:0] hcnt, nh;
    logic [VW-1:0] vcnt, nv;
    logic [1:0]    pat, npat;
    logic [7:0]    ncnt, x;
    logic [3:0]    y, px;
    logic          div_wrap, tick, h_last, frame_end, go, de, vs;
    // nh/nv/npat/ncnt describe the pixel about to be emitted on this tick
    always_comb begin
        div_wrap  = div == DW'(CLK_DIV - 1);
        tick      = div_wrap && bus.rgb_clk;
        h_last    = hcnt == HW'(H_TOTAL - 1);
        frame_end = state == RUN && h_last && vcnt == VW'(V_TOTAL - 1);
        go        = state == IDLE ? bus.en : !frame_end || bus.en;
        nh        = state == IDLE || h_last ? '0 : hcnt + HW'(1);
        nv        = state == IDLE || frame_end ? '0 : h_last ? vcnt + VW'(1) : vcnt;
        npat      = state == IDLE || frame_end ? bus.pattern_sel : pat;
        ncnt      = frame_end ? bus.frame_cnt + 8'd1 : bus.frame_cnt;
        x         = 8'(nh);
        y         = 4'(nv);
        de        = go && 32'(nh) < H_ACTIVE && 32'(nv) < V_ACTIVE;
        vs        = go && 32'(nv) >= V_ACTIVE && 32'(nv) < V_ACTIVE + VSYNC_LINES;
        px        = !de ? 4'd0 :
                    npat == 2'd0 ? bus.fill :
                    npat == 2'd1 ? x[7:4] + ncnt[3:0] :
                    npat == 2'd2 ? {4{x[3] ^ y[3]}} : x[3:0] ^ y;
    end
    always_ff @(posedge clk_8m or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            div            <= '0;
            hcnt           <= '0;
            vcnt           <= '0;
            pat            <= '0;
            bus.rgb_clk    <= 1'b0;
            bus.rgb_de     <= 1'b0;
            bus.rgb_vsync  <= 1'b0;
            bus.rgb_data   <= '0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.frame_cnt  <= '0;
        end else begin
            div            <= div_wrap ? '0 : div + DW'(1);
            bus.rgb_clk    <= bus.rgb_clk ^ div_wrap;
            bus.frame_done <= tick && frame_end;
            if (tick) begin
                state         <= go ? RUN : IDLE;
                hcnt          <= nh;
                vcnt          <= nv;
                pat           <= npat;
                bus.frame_cnt <= ncnt;
                bus.busy      <= go;
                bus.rgb_de    <= de;
                bus.rgb_vsync <= vs;
                bus.rgb_data  <= px;
            end
        end
    end
endmodule

// File: tb/tb_dpi_pattern_tx.sv
// tb_dpi_pattern_tx: randomized self-checking bench for dpi_pattern_tx against a pixel-index reference model
module tb_dpi_pattern_tx;
    localparam int HA = 20, HB = 4, VA = 18, VB = 4, VS = 2, CD = 1;
    localparam int HT = HA + HB, VT = VA + VB, FR = HT * VT, FC = FR * 2 * CD;
    logic clk_8m = 1'b0, rst = 1'b1, rst_b = 1'b1;
    int   n_cmp = 0, n_err = 0;
    always #5 clk_8m = ~clk_8m;
    dpi_pattern_tx_if bus_a ();
    dpi_pattern_tx_if bus_b ();
    dpi_pattern_tx #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .VSYNC_LINES(VS), .CLK_DIV(CD))
        dut_a (.clk_8m(clk_8m), .rst(rst), .bus(bus_a));
    dpi_pattern_tx #(.H_ACTIVE(17), .H_BLANK(1), .V_ACTIVE(1), .V_BLANK(1), .VSYNC_LINES(1), .CLK_DIV(2))
        dut_b (.clk_8m(clk_8m), .rst(rst_b), .bus(bus_b));
    int         m_cyc = 0, m_p = 0;
    bit         m_run = 0;
    logic [1:0] m_pat = 0;
    logic [7:0] m_fc = 0;
    logic       m_clk = 0, m_de = 0, m_vs = 0, m_busy = 0, m_done = 0;
    logic [3:0] m_data = 0;
    logic [16:0] obs, expv;
    assign obs  = {bus_a.rgb_clk, bus_a.rgb_de, bus_a.rgb_vsync, bus_a.rgb_data, bus_a.busy, bus_a.frame_done, bus_a.frame_cnt};
    assign expv = {m_clk, m_de, m_vs, m_data, m_busy, m_done, m_fc};
    // model: pixel p of the frame sits at x = p % HT, y = p / HT; one pixel per 2*CD clocks
    initial begin : model
        int x, y, d;
        forever begin
            @(posedge clk_8m or posedge rst);
            if (rst) begin
                m_cyc = 0; m_p = 0; m_run = 0; m_pat = 0; m_fc = 0;
                m_clk = 0; m_de = 0; m_vs = 0; m_data = 0; m_busy = 0; m_done = 0;
            end else begin
                m_cyc++;
                m_done = 0;
                if (m_cyc % (2 * CD) == 0) begin
                    if (m_run && m_p == FR - 1) begin
                        m_done = 1; m_fc = m_fc + 8'd1; m_run = bus_a.en; m_p = 0; m_pat = bus_a.pattern_sel;
                    end else if (m_run) m_p++;
                    else if (bus_a.en) begin
                        m_run = 1; m_p = 0; m_pat = bus_a.pattern_sel;
                    end
                    x = m_p % HT;
                    y = m_p / HT;
                    case (m_pat)
                        2'd0:    d = int'(bus_a.fill);
                        2'd1:    d = (x / 16 + int'(m_fc)) % 16;
                        2'd2:    d = ((x / 8) % 2 != (y / 8) % 2) ? 15 : 0;
                        default: d = (x % 16) ^ (y % 16);
                    endcase
                    m_de   = m_run && x < HA && y < VA;
                    m_vs   = m_run && y >= VA && y < VA + VS;
                    m_data = m_de ? 4'(d) : 4'd0;
                    m_busy = m_run;
                end
                m_clk = ((m_cyc / CD) % 2) != 0;
            end
        end
    end
    task automatic test_reset();
        repeat (3) @(negedge clk_8m);
        n_cmp++;
        if (obs !== 17'd0) begin n_err++; $display("FAIL reset_state_a: got %h want %h", obs, 17'd0); end
        n_cmp++;
        if ({bus_b.rgb_clk, bus_b.rgb_de, bus_b.busy, bus_b.frame_cnt} !== 11'd0) begin
            n_err++; $display("FAIL reset_state_b: got %h want 0", {bus_b.rgb_clk, bus_b.rgb_de, bus_b.busy, bus_b.frame_cnt});
        end
        rst = 1'b0;
        @(negedge clk_8m);
        n_cmp++;
        if (bus_a.rgb_clk !== 1'b1) begin n_err++; $display("FAIL first_rise: got %b want 1", bus_a.rgb_clk); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_8m);
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL idle cyc %0d: got %h want %h", i, obs, expv); end
        end
    endtask
    task automatic test_raster();
        logic       prev_clk;
        logic [4:0] prev_dd;
        bit         counting = 0, done_seen = 0;
        int         de_cnt = 0, vs_cnt = 0;
        bus_a.pattern_sel = 2'd3;
        bus_a.en = 1'b1;
        prev_clk = bus_a.rgb_clk;
        prev_dd  = {bus_a.rgb_de, bus_a.rgb_data};
        for (int i = 0; i < FC + 40; i++) begin
            @(negedge clk_8m);
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL raster cyc %0d: got %h want %h", i, obs, expv); end
            if ({bus_a.rgb_de, bus_a.rgb_data} != prev_dd) begin
                n_cmp++;
                if (!(prev_clk === 1'b1 && bus_a.rgb_clk === 1'b0)) begin
                    n_err++; $display("FAIL data_edge cyc %0d: rgb_clk %b->%b want 1->0", i, prev_clk, bus_a.rgb_clk);
                end
            end
            if (m_busy && m_p == 9 * HT + 5) begin
                n_cmp++;
                if (bus_a.rgb_data !== 4'hC) begin n_err++; $display("FAIL px_5_9: got %h want c", bus_a.rgb_data); end
            end
            if (m_busy && m_p == 15 * HT + 15) begin
                n_cmp++;
                if (bus_a.rgb_data !== 4'h0) begin n_err++; $display("FAIL px_15_15: got %h want 0", bus_a.rgb_data); end
            end
            if (bus_a.frame_done === 1'b1) done_seen = 1;
            counting = bus_a.busy === 1'b1 && !done_seen;
            if (counting && bus_a.rgb_de === 1'b1) de_cnt++;
            if (counting && bus_a.rgb_vsync === 1'b1) vs_cnt++;
            prev_clk = bus_a.rgb_clk;
            prev_dd  = {bus_a.rgb_de, bus_a.rgb_data};
        end
        n_cmp++;
        if (de_cnt != HA * VA * 2 * CD) begin n_err++; $display("FAIL de_count: got %0d want %0d", de_cnt, HA * VA * 2 * CD); end
        n_cmp++;
        if (vs_cnt != VS * HT * 2 * CD) begin n_err++; $display("FAIL vsync_count: got %0d want %0d", vs_cnt, VS * HT * 2 * CD); end
    endtask
    task automatic test_fill_midframe();
        int t = 0;
        bus_a.pattern_sel = 2'd0;
        bus_a.fill = 4'hA;
        while (m_done !== 1'b1 && t < FC + 10) begin
            @(negedge clk_8m);
            t++;
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL fill_sync cyc %0d: got %h want %h", t, obs, expv); end
        end
        n_cmp++;
        if (t >= FC + 10) begin n_err++; $display("FAIL fill_sync_timeout: got %0d cycles want <%0d", t, FC + 10); end
        for (int i = 1; i < FC; i++) begin
            @(negedge clk_8m);
            if (i == FC / 2) bus_a.pattern_sel = 2'd2;
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL fill cyc %0d: got %h want %h", i, obs, expv); end
            n_cmp++;
            if (bus_a.rgb_data !== (bus_a.rgb_de ? 4'hA : 4'h0)) begin
                n_err++; $display("FAIL solid_px cyc %0d: got %h want %h", i, bus_a.rgb_data, bus_a.rgb_de ? 4'hA : 4'h0);
            end
        end
        @(negedge clk_8m);
        n_cmp++;
        if ({bus_a.frame_done, bus_a.rgb_de, bus_a.rgb_data} !== 6'b11_0000) begin
            n_err++; $display("FAIL checker_0_0: got %b want 110000", {bus_a.frame_done, bus_a.rgb_de, bus_a.rgb_data});
        end
        repeat (8 * 2 * CD) @(negedge clk_8m);
        n_cmp++;
        if (bus_a.rgb_data !== 4'hF) begin n_err++; $display("FAIL checker_8_0: got %h want f", bus_a.rgb_data); end
    endtask
    task automatic test_en_drop();
        int         t = 0, toggles = 0;
        logic [7:0] cnt0;
        logic       pc;
        while (!(m_busy && m_p == 10 * HT) && t < 2 * FC) begin @(negedge clk_8m); t++; end
        cnt0 = bus_a.frame_cnt;
        bus_a.en = 1'b0;
        t = 0;
        while (bus_a.frame_done !== 1'b1 && t < FC + 10) begin
            @(negedge clk_8m);
            t++;
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL en_drop cyc %0d: got %h want %h", t, obs, expv); end
        end
        n_cmp++;
        if (bus_a.frame_done !== 1'b1) begin n_err++; $display("FAIL en_drop_done: got %b want 1", bus_a.frame_done); end
        n_cmp++;
        if (bus_a.frame_cnt !== cnt0 + 8'd1) begin n_err++; $display("FAIL en_drop_cnt: got %0d want %0d", bus_a.frame_cnt, cnt0 + 8'd1); end
        pc = bus_a.rgb_clk;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_8m);
            n_cmp++;
            if ({bus_a.busy, bus_a.rgb_de, bus_a.rgb_vsync, bus_a.rgb_data} !== 7'd0) begin
                n_err++; $display("FAIL idle_out cyc %0d: got %b want 0", i, {bus_a.busy, bus_a.rgb_de, bus_a.rgb_vsync, bus_a.rgb_data});
            end
            if (bus_a.rgb_clk !== pc) toggles++;
            pc = bus_a.rgb_clk;
        end
        n_cmp++;
        if (toggles != 40 / CD) begin n_err++; $display("FAIL idle_clk_toggles: got %0d want %0d", toggles, 40 / CD); end
    endtask
    task automatic test_reset_mid();
        int t = 0;
        bit seen = 0;
        bus_a.pattern_sel = 2'd0;
        bus_a.fill = 4'h5;
        bus_a.en = 1'b1;
        while (!(m_busy && m_p == 5 * HT + 3) && t < 2 * FC) begin @(negedge clk_8m); t++; end
        @(negedge clk_8m);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 17'd0) begin n_err++; $display("FAIL async_reset: got %h want %h", obs, 17'd0); end
        repeat (2) @(negedge clk_8m);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_8m);
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL post_reset cyc %0d: got %h want %h", i, obs, expv); end
            if (!seen && bus_a.busy === 1'b1) begin
                seen = 1;
                n_cmp++;
                if ({bus_a.rgb_de, bus_a.rgb_data} !== 5'b1_0101) begin
                    n_err++; $display("FAIL first_px: got %b want 10101", {bus_a.rgb_de, bus_a.rgb_data});
                end
            end
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL restart_timeout: got busy=0 want busy=1"); end
    endtask
    task automatic test_random();
        for (int i = 0; i < 4500; i++) begin
            @(negedge clk_8m);
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL random cyc %0d: got %h want %h", i, obs, expv); end
            if ($urandom_range(0, 199) == 0) bus_a.en = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 49) == 0) bus_a.pattern_sel = 2'($urandom);
            if ($urandom_range(0, 29) == 0) bus_a.fill = 4'($urandom);
        end
    endtask
    task automatic test_wrap();
        int t;
        bus_b.en = 1'b1;
        bus_b.pattern_sel = 2'd1;
        bus_b.fill = 4'h0;
        @(negedge clk_8m);
        rst_b = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            t = k > 1 ? 64 : 0;
            do begin @(negedge clk_8m); t++; end while (bus_b.frame_done !== 1'b1 && t < 400);
            n_cmp++;
            if (t >= 400) begin n_err++; $display("FAIL wrap_timeout frame %0d: got %0d cycles want <400", k, t); break; end
            if (k > 1) begin
                n_cmp++;
                if (t != 144) begin n_err++; $display("FAIL frame_period %0d: got %0d want 144", k, t); end
            end
            n_cmp++;
            if (bus_b.frame_cnt !== 8'(k)) begin n_err++; $display("FAIL frame_cnt %0d: got %0d want %0d", k, bus_b.frame_cnt, 8'(k)); end
            repeat (64) @(negedge clk_8m);
            n_cmp++;
            if (bus_b.rgb_data !== 4'((1 + k) % 16)) begin
                n_err++; $display("FAIL grad_x16 frame %0d: got %h want %h", k, bus_b.rgb_data, 4'((1 + k) % 16));
            end
        end
    endtask
    initial begin
        bus_a.en = 1'b0; bus_a.pattern_sel = 2'd0; bus_a.fill = 4'h0;
        bus_b.en = 1'b0; bus_b.pattern_sel = 2'd0; bus_b.fill = 4'h0;
        test_reset();
        test_raster();
        test_fill_midframe();
        test_en_drop();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dpi_pattern_tx.md
# dpi_pattern_tx

Synthetic RGB/DPI video transmitter. It generates the same pixel-clock / data-enable / vsync / 4-bit data stream that the Raspberry Pi drives into the video sampler. The block runs on `clk_8m` and feeds a pattern-generated raster into the sampler's `rgb_*` inputs, so the sampler→vram→LCD path can be self-tested without a Pi attached. Frame geometry is parameterised, and the pattern is selected per frame.

## Interface
Parameters:
- `H_ACTIVE`, 320: active pixels per line.
- `H_BLANK`, 40: blank pixels per line. `H_TOTAL = H_ACTIVE + H_BLANK`.
- `V_ACTIVE`, 288: active lines per frame.
- `V_BLANK`, 8: blank lines per frame. `V_TOTAL = V_ACTIVE + V_BLANK`.
- `VSYNC_LINES`, 2: vsync width in lines. Must be ≥1 and ≤ `V_BLANK`.
- `CLK_DIV`, 2: `clk_8m` cycles per `rgb_clk` half-period. Must be ≥1.

Ports (one clock, `clk_8m`; reset `rst` is asynchronous and active-high):
- `clk_8m` in 1: system clock.
- `rst` in 1: asynchronous active-high reset.
- `en` in 1: run request, sampled at frame boundaries.
- `pattern_sel` in 2: 0 solid, 1 gradient, 2 checker, 3 xor.
- `fill` in 4: pixel value used by solid mode.
- `rgb_clk` out 1: pixel clock.
- `rgb_de` out 1: data enable.
- `rgb_vsync` out 1: vertical sync, active-high.
- `rgb_data` out 4: pixel value.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-`clk_8m` pulse at the end of each frame.
- `frame_cnt` out 8: completed frames, wraps at 255→0.

## Operation
Pixel clock:
- A divider counter `div` runs 0..CLK_DIV-1. `rgb_clk` toggles when `div` wraps, so its period is `2*CLK_DIV` clk cycles.
- `rgb_clk` runs continuously out of reset, including while idle.
- Pixel tick: the clk cycle in which `rgb_clk` goes 1→0. All raster state and the `rgb_de`/`rgb_vsync`/`rgb_data` registers update only on pixel ticks. The receiver therefore sees stable data at the `rgb_clk` rising edge.

States:
- IDLE: outputs de=0, vsync=0, data=0; `hcnt = vcnt = 0`. On a pixel tick with `en=1`: latch `pattern_sel`→`pat`, go to RUN, `busy=1`, and emit pixel (0,0) on this same tick.
- RUN: on each pixel tick, advance `hcnt` by 1. When `hcnt` wraps H_TOTAL-1→0, advance `vcnt`.
  - On the tick that would step from (H_TOTAL-1, V_TOTAL-1): pulse `frame_done` for one clk cycle and increment `frame_cnt`.
  - If `en=1` at that tick: relatch `pat` and continue with pixel (0,0).
  - If `en=0`: go to IDLE, `busy=0`, all outputs 0.
- `en` falling mid-frame has no effect until the frame ends; frames always complete. `pattern_sel` changes mid-frame are ignored.

Output decode, registered from the (hcnt, vcnt) being emitted:
- `rgb_de = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE)`.
- `rgb_vsync = (vcnt >= V_ACTIVE) && (vcnt < V_ACTIVE + VSYNC_LINES)`.
- `rgb_data = 0` when de=0. When de=1, with x=hcnt and y=vcnt:
  - `pat` 0: `fill`.
  - `pat` 1: `x[7:4] + frame_cnt[3:0]`, mod 16.
  - `pat` 2: `{4{x[3]^y[3]}}`.
  - `pat` 3: `x[3:0] ^ y[3:0]`.

Counters and widths:
- `hcnt` and `vcnt` are `$clog2(H_TOTAL)` and `$clog2(V_TOTAL)` bits wide.
- All compares are unsigned.

## Timing
- Reset values: `rgb_clk=0`, `rgb_de=0`, `rgb_vsync=0`, `rgb_data=0`, `busy=0`, `frame_done=0`, `frame_cnt=0`, `div=0`, state IDLE.
- Reset is effective immediately and asynchronously, including mid-frame. Release is synchronous to `clk_8m`.
- First `rgb_clk` rise occurs CLK_DIV cycles after reset release. First pixel tick occurs 2*CLK_DIV cycles after release.
- Latency from `en` rising to first `rgb_de=1`: ≤ 2*CLK_DIV + 1 clk cycles from IDLE.
- `rgb_de`, `rgb_vsync` and `rgb_data` change only in the clk cycle following a pixel tick. They are held constant for a full `rgb_clk` period.
- `frame_done` asserts in the cycle after the final pixel tick of the frame, simultaneously with the `frame_cnt` increment.
- Frame period is `H_TOTAL * V_TOTAL * 2 * CLK_DIV` clk cycles, with no gap between back-to-back frames.

## Test plan
- Reset then `en=1`, defaults: exactly 320 de-high pixels per line, 288 de lines, vsync high for lines 288–289 only. `frame_done` period = 360*296*4 = 426240 clk cycles.
- Pattern 3, `CLK_DIV=1`: pixel (5,9) = 4'hC and pixel (15,15) = 4'h0. Every data/de change coincides with an `rgb_clk` falling edge.
- Pattern 0 with `fill=4'hA`: all de pixels are 4'hA and all non-de pixels are 0. Changing `pattern_sel` to 2 mid-frame → no change until the next frame, which starts with pixel (0,0) = 0 and pixel (8,0) = 4'hF.
- Drop `en` at line 100: the frame completes, `frame_done` pulses, `frame_cnt` increments by 1, then `busy=0`, outputs stay 0 and `rgb_clk` keeps toggling.
- Assert `rst` mid-line 50: all outputs 0 asynchronously and `frame_cnt=0`. After release with `en=1`, the first pixel is (0,0).
- Run 256 frames in pattern 1: `frame_cnt` wraps to 0. Pixel x=16 in frame 15 = 4'h0 ((1+15) mod 16).
